// File: rtl/hwpe_ctrl_periph_arbiter.sv
// hwpe_ctrl_periph_arbiter: round-robin N-to-1 peripheral port arbiter with in-order response routing
module hwpe_ctrl_periph_arbiter #(
    parameter int N_CHAN          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [N_CHAN-1:0]              m_req_i,
    output logic [N_CHAN-1:0]              m_gnt_o,
    input  logic [N_CHAN*ADDR_WIDTH-1:0]   m_add_i,
    input  logic [N_CHAN-1:0]              m_wen_i,
    input  logic [N_CHAN*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [N_CHAN*DATA_WIDTH-1:0]   m_data_i,
    input  logic [N_CHAN*ID_WIDTH-1:0]     m_id_i,
    output logic [N_CHAN*DATA_WIDTH-1:0]   m_r_data_o,
    output logic [N_CHAN-1:0]              m_r_valid_o,
    output logic [N_CHAN*ID_WIDTH-1:0]     m_r_id_o,
    output logic                           s_req_o,
    output logic [ADDR_WIDTH-1:0]          s_add_o,
    output logic                           s_wen_o,
    output logic [DATA_WIDTH/8-1:0]        s_be_o,
    output logic [DATA_WIDTH-1:0]          s_data_o,
    output logic [ID_WIDTH-1:0]            s_id_o,
    input  logic                           s_gnt_i,
    input  logic [DATA_WIDTH-1:0]          s_r_data_i,
    input  logic                           s_r_valid_i,
    input  logic [ID_WIDTH-1:0]            s_r_id_i,
    output logic                           busy_o,
    output logic                           err_o
);
    localparam int IW = $clog2(N_CHAN);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = DATA_WIDTH / 8;

    logic [IW-1:0] rr_ptr, win, head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic          full, push, pop, err_q;

    // descending offset scan so the channel closest to rr_ptr is the last (winning) assignment
    always_comb begin
        win = '0;
        for (int k = N_CHAN - 1; k >= 0; k--)
            if (m_req_i[(int'(rr_ptr) + k) % N_CHAN]) win = IW'((int'(rr_ptr) + k) % N_CHAN);
    end

    assign full     = cnt == CW'(MAX_OUTSTANDING);
    assign s_req_o  = rst_ni & (|m_req_i) & ~full & ~clear_i;
    assign s_add_o  = m_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wen_o  = m_wen_i[win];
    assign s_be_o   = m_be_i[int'(win)*BW +: BW];
    assign s_data_o = m_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    assign s_id_o   = m_id_i[int'(win)*ID_WIDTH +: ID_WIDTH];
    assign push     = s_req_o & s_gnt_i;
    assign m_gnt_o  = push ? N_CHAN'(1) << win : '0;

    assign head        = fifo_q[rd_ptr];
    assign pop         = s_r_valid_i & (cnt != '0);
    assign m_r_valid_o = pop ? N_CHAN'(1) << head : '0;
    assign busy_o      = cnt != '0;
    assign err_o       = err_q;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_rsp
        assign m_r_data_o[c*DATA_WIDTH +: DATA_WIDTH] = m_r_valid_o[c] ? s_r_data_i : '0;
        assign m_r_id_o[c*ID_WIDTH +: ID_WIDTH]       = m_r_valid_o[c] ? s_r_id_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else if (clear_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= win == IW'(N_CHAN - 1) ? '0 : win + IW'(1);
                wr_ptr <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            if (s_r_valid_i && cnt == '0)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fifo_q[wr_ptr] <= win;
    end
endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// tb_hwpe_ctrl_periph_arbiter: directed and random checks of the arbiter against a queue-based model
module tb_hwpe_ctrl_periph_arbiter;
    localparam int N  = 3;
    localparam int MO = 4;

    logic          clk_i = 0;
    logic          rst_ni, clear_i;
    logic [N-1:0]  m_req_i, m_gnt_o, m_wen_i, m_r_valid_o, m_id_i, m_r_id_o;
    logic [N*32-1:0] m_add_i, m_data_i, m_r_data_o;
    logic [N*4-1:0]  m_be_i;
    logic          s_req_o, s_wen_o, s_id_o, s_gnt_i, s_r_valid_i, s_r_id_i, busy_o, err_o;
    logic [31:0]   s_add_o, s_data_o, s_r_data_i;
    logic [3:0]    s_be_o;

    int vectors = 0, miscompares = 0;
    int q[$];
    int rr = 0;
    bit err_m = 0;

    hwpe_ctrl_periph_arbiter #(.N_CHAN(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1),
                               .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
        .m_be_i(m_be_i), .m_data_i(m_data_i), .m_id_i(m_id_i),
        .m_r_data_o(m_r_data_o), .m_r_valid_o(m_r_valid_o), .m_r_id_o(m_r_id_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o), .s_be_o(s_be_o),
        .s_data_o(s_data_o), .s_id_o(s_id_o), .s_gnt_i(s_gnt_i), .s_r_data_i(s_r_data_i),
        .s_r_valid_i(s_r_valid_i), .s_r_id_i(s_r_id_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic gnt, input logic rv,
                        input logic clr, input logic [31:0] rd);
        int win;
        bit esreq, acc, epop;
        logic [127:0] erd;
        logic [N-1:0] erv, erid;
        @(negedge clk_i);
        m_req_i = req; s_gnt_i = gnt; s_r_valid_i = rv; clear_i = clr; s_r_data_i = rd;
        s_r_id_i = 1'($urandom); m_add_i = {$urandom, $urandom, $urandom};
        m_data_i = {$urandom, $urandom, $urandom}; m_be_i = 12'($urandom);
        m_wen_i = N'($urandom); m_id_i = N'($urandom);
        #1;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && req[(rr + k) % N]) win = (rr + k) % N;
        esreq = win >= 0 && q.size() < MO && !clr;
        acc   = esreq && gnt;
        epop  = rv && q.size() > 0;
        erv   = epop ? N'(1) << q[0] : '0;
        erid  = epop ? N'(s_r_id_i) << q[0] : '0;
        erd   = epop ? {96'b0, rd} << (32 * q[0]) : '0;
        chk("s_req", 128'(s_req_o), 128'(esreq));
        chk("m_gnt", 128'(m_gnt_o), acc ? 128'(1) << win : 128'(0));
        if (esreq)
            chk("s_fields", {s_add_o, s_wen_o, s_be_o, s_data_o, s_id_o},
                {m_add_i[win*32 +: 32], m_wen_i[win], m_be_i[win*4 +: 4],
                 m_data_i[win*32 +: 32], m_id_i[win]});
        chk("r_valid", 128'(m_r_valid_o), 128'(erv));
        chk("r_data", 128'(m_r_data_o), erd);
        chk("r_id", 128'(m_r_id_o), 128'(erid));
        chk("busy", 128'(busy_o), 128'(q.size() != 0));
        chk("err", 128'(err_o), 128'(err_m));
        @(posedge clk_i);
        if (clr) begin
            q.delete(); rr = 0; err_m = 0;
        end else begin
            if (rv && q.size() == 0) err_m = 1;
            if (epop) void'(q.pop_front());
            if (acc) begin q.push_back(win); rr = (win + 1) % N; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0; m_req_i = '1; s_gnt_i = 1; s_r_valid_i = 1; clear_i = 0;
        #1;
        chk("rst_s_req", 128'(s_req_o), 128'(0));
        chk("rst_gnt", 128'(m_gnt_o), 128'(0));
        chk("rst_r_valid", 128'(m_r_valid_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        q.delete(); rr = 0; err_m = 0;
        @(negedge clk_i);
        rst_ni = 1; s_r_valid_i = 0; m_req_i = '0;
    endtask

    initial begin
        rst_ni = 0; clear_i = 0; m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 0; s_r_id_i = 0;
        s_r_data_i = '0; m_add_i = '0; m_data_i = '0; m_be_i = '0; m_wen_i = '0; m_id_i = '0;
        repeat (2) @(posedge clk_i);
        do_reset();
        // alternation 0,1,0,1 fills the FIFO; full blocks even during the pop cycle
        for (int i = 0; i < 6; i++) step(3'b011, 1, 0, 0, $urandom);
        step(3'b011, 1, 1, 0, $urandom);
        step(3'b011, 1, 0, 0, $urandom);
        for (int i = 0; i < 5; i++) step(3'b000, 0, 1, 0, $urandom);
        // single ch1 read returned two cycles later
        step(3'b000, 0, 0, 1, 0);
        step(3'b010, 1, 0, 0, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        step(3'b000, 0, 1, 0, 32'hCAFE0001);
        step(3'b000, 0, 0, 0, $urandom);
        // spurious response sets sticky error, clear drops it
        step(3'b000, 0, 1, 0, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        step(3'b000, 0, 0, 1, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        // ch2, ch0, ch1 outstanding, then clear
        step(3'b100, 1, 0, 0, $urandom);
        step(3'b001, 1, 0, 0, $urandom);
        step(3'b010, 1, 0, 0, $urandom);
        step(3'b111, 1, 0, 1, $urandom);
        step(3'b111, 1, 0, 0, $urandom);
        step(3'b000, 0, 1, 0, $urandom);
        step(3'b000, 0, 1, 0, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        // reset mid-burst with outstanding entries
        step(3'b011, 1, 0, 0, $urandom);
        step(3'b011, 1, 0, 0, $urandom);
        do_reset();
        step(3'b110, 1, 0, 0, $urandom);
        step(3'b000, 0, 1, 0, $urandom);
        step(3'b000, 0, 1, 0, $urandom);
        step(3'b000, 0, 0, 0, $urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(N'($urandom), $urandom_range(0, 9) < 7,
                 q.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0,
                 $urandom_range(0, 49) == 0, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
